// File: rtl/button_pkg.sv
// Shared command codes, FSM states and timing helper for the button press generator.
package button_pkg;

  localparam logic [1:0] BTN_CMD_SHORT  = 2'b00;
  localparam logic [1:0] BTN_CMD_LONG   = 2'b01;
  localparam logic [1:0] BTN_CMD_CUSTOM = 2'b10;
  localparam logic [1:0] BTN_CMD_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_PRESS  = 2'd2,
    ST_GAP    = 2'd3
  } btn_state_e;

  function automatic int unsigned ms_delay(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/button_press_generator_ms_tick_gen.sv
// Millisecond tick generator with a synchronous restart so every phase starts on a fresh ms boundary.
module ms_tick_gen #(
  parameter int unsigned MS_DELAY = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick,
  output logic sub_tick
);

  localparam int unsigned SUB_DELAY = MS_DELAY / 8;
  localparam int CW = (MS_DELAY > 1) ? $clog2(MS_DELAY) : 1;
  localparam int SW = (SUB_DELAY > 1) ? $clog2(SUB_DELAY) : 1;

  logic [CW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] sub_q, sub_d;

  assign tick     = (cyc_q == CW'(MS_DELAY - 1));
  assign sub_tick = (sub_q == SW'(SUB_DELAY - 1));

  always_comb begin
    cyc_d = tick ? '0 : cyc_q + CW'(1);
    sub_d = sub_tick ? '0 : sub_q + SW'(1);
    if (restart) begin
      cyc_d = '0;
      sub_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cyc_q <= '0;
      sub_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      sub_q <= sub_d;
    end
  end

endmodule

// File: rtl/button_press_generator.sv
// Synthesizes an active-low push-button waveform (bounce, hold, release gap) from software commands.
//   state     | meaning
//   ST_IDLE   | ready for a command, btn_n released
//   ST_BOUNCE | start of press, btn_n chatters every MS_DELAY/8 cycles
//   ST_PRESS  | btn_n held low until the low phase totals len_ms
//   ST_GAP    | btn_n released for GAP_MS before next press or done
module button_press_generator
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 0,
  parameter int unsigned SHORT_MS  = 100,
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned GAP_MS    = 50,
  parameter int unsigned BOUNCE_MS = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [15:0] cmd_ms,
  input  logic [3:0]  cmd_count,
  output logic        btn_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned MS_DELAY  = ms_delay(CLK_HZ);
  localparam logic [15:0] BOUNCE_16 = 16'(BOUNCE_MS);
  localparam logic [15:0] GAP_16    = 16'(GAP_MS);

  btn_state_e  state_q, state_d;
  logic [15:0] ms_q, ms_d;
  logic [15:0] len_q, len_d;
  logic [3:0]  press_q, press_d;
  logic        btn_n_q, btn_n_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        restart, tick, sub_tick;
  logic [15:0] cmd_len, press_ms;
  logic        cmd_bad, ms_last;

  ms_tick_gen #(.MS_DELAY(MS_DELAY)) u_tick (
    .clk      (clk),
    .rstn     (rstn),
    .restart  (restart),
    .tick     (tick),
    .sub_tick (sub_tick)
  );

  assign cmd_len = (cmd_type == BTN_CMD_SHORT) ? 16'(SHORT_MS) :
                   (cmd_type == BTN_CMD_LONG)  ? 16'(LONG_MS)  : cmd_ms;
  assign cmd_bad = (cmd_type == BTN_CMD_RSVD) ||
                   ((cmd_type == BTN_CMD_CUSTOM) && (cmd_ms == 16'd0));
  // Steady-low part of the press; clamp keeps an oversized bounce from underflowing
  assign press_ms = (BOUNCE_MS == 0) ? len_q :
                    (len_q > BOUNCE_16) ? (len_q - BOUNCE_16) : 16'd1;
  assign ms_last  = tick && (ms_q == 16'd1);

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    len_d   = len_q;
    press_d = press_q;
    btn_n_d = btn_n_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        btn_n_d = 1'b1;
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            len_d   = cmd_len;
            press_d = (cmd_count == 4'd0) ? 4'd1 : cmd_count;
            btn_n_d = 1'b0;
            if (BOUNCE_MS == 0) begin
              state_d = ST_PRESS;
              ms_d    = cmd_len;
            end else begin
              state_d = ST_BOUNCE;
              ms_d    = BOUNCE_16;
            end
          end
        end
      end
      ST_BOUNCE: begin
        if (sub_tick) btn_n_d = ~btn_n_q;
        if (ms_last) begin
          state_d = ST_PRESS;
          ms_d    = press_ms;
          btn_n_d = 1'b0;
          restart = 1'b1;
        end else if (tick) begin
          ms_d = ms_q - 16'd1;
        end
      end
      ST_PRESS: begin
        if (ms_last) begin
          state_d = ST_GAP;
          ms_d    = GAP_16;
          btn_n_d = 1'b1;
          restart = 1'b1;
        end else if (tick) begin
          ms_d = ms_q - 16'd1;
        end
      end
      ST_GAP: begin
        if (ms_last) begin
          restart = 1'b1;
          if (press_q > 4'd1) begin
            press_d = press_q - 4'd1;
            btn_n_d = 1'b0;
            if (BOUNCE_MS == 0) begin
              state_d = ST_PRESS;
              ms_d    = len_q;
            end else begin
              state_d = ST_BOUNCE;
              ms_d    = BOUNCE_16;
            end
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          ms_d = ms_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ms_q    <= '0;
      len_q   <= '0;
      press_q <= '0;
      btn_n_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      len_q   <= len_d;
      press_q <= press_d;
      btn_n_q <= btn_n_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign btn_n     = btn_n_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_button_press_generator.sv
// Self-checking bench: two generators (bounce 2 ms and bounce 0) against a per-cycle waveform model.
module tb_button_press_generator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = 2'b00;
  logic [15:0] cmd_ms = 16'd0;
  logic [3:0]  cmd_count = 4'd0;
  logic ready2, btn2, busy2, done2, err2;
  logic ready0, btn0, busy0, done0, err0;

  always #5 clk = ~clk;

  button_press_generator #(.CLK_HZ(8000), .BOUNCE_MS(2)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(ready2),
    .cmd_type(cmd_type), .cmd_ms(cmd_ms), .cmd_count(cmd_count),
    .btn_n(btn2), .busy(busy2), .done(done2), .err(err2));

  button_press_generator #(.CLK_HZ(8000), .BOUNCE_MS(0)) dut0 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(ready0),
    .cmd_type(cmd_type), .cmd_ms(cmd_ms), .cmd_count(cmd_count),
    .btn_n(btn0), .busy(busy0), .done(done0), .err(err0));

  typedef struct packed {
    logic b2; logic b0; logic busy; logic done; logic err; logic ready;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;
  int   falls = 0, dones = 0, acc_cyc = 0, done_cyc = 0;
  logic cur_ready = 1'b1;
  logic prev_b0 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic b2, input logic b0, input logic bsy,
                              input logic dn, input logic er, input logic rdy);
    exp_t e;
    e.b2 = b2; e.b0 = b0; e.busy = bsy; e.done = dn; e.err = er; e.ready = rdy;
    return e;
  endfunction

  // Expected outputs for every cycle after an accept: presses, gaps, then the done cycle
  task automatic model_push(input logic [1:0] t, input logic [15:0] ms, input logic [3:0] cnt);
    int len, n;
    if (t == 2'b11 || (t == 2'b10 && ms == 16'd0)) begin
      q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
      return;
    end
    len = (t == 2'b00) ? 100 : (t == 2'b01) ? 500 : int'(ms);
    n   = (cnt == 4'd0) ? 1 : int'(cnt);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < len * 8; i++)
        q.push_back(mk((i < 16) && (i % 2 == 1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 400; i++)
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
  endtask

  task automatic tick_check();
    exp_t e;
    @(negedge clk);
    cyc++;
    e = (q.size() > 0) ? q.pop_front() : mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("btn_n", 32'({btn2, btn0}), 32'({e.b2, e.b0}));
    chk("busy",  32'({busy2, busy0}), 32'({e.busy, e.busy}));
    chk("done",  32'({done2, done0}), 32'({e.done, e.done}));
    chk("err",   32'({err2, err0}), 32'({e.err, e.err}));
    chk("ready", 32'({ready2, ready0}), 32'({e.ready, e.ready}));
    if (prev_b0 && !btn0) falls++;
    prev_b0 = btn0;
    if (done0) begin
      dones++;
      done_cyc = cyc;
    end
    cur_ready = e.ready;
  endtask

  task automatic send(input logic [1:0] t, input logic [15:0] ms, input logic [3:0] cnt,
                      input bit keep);
    int guard = 0;
    cmd_type = t; cmd_ms = ms; cmd_count = cnt; cmd_valid = 1'b1;
    while (!cur_ready && guard < 20000) begin
      tick_check();
      guard++;
    end
    chk("accept_wait", 32'(cur_ready), 32'd1);
    acc_cyc = cyc;
    model_push(t, ms, cnt);
    tick_check();
    if (!keep) cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_ms    = 16'($urandom);
    cmd_count = 4'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    cmd_valid = 1'b0;
    while (q.size() > 0 && g < 30000) begin
      tick_check();
      g++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (3) tick_check();
  endtask

  initial begin
    int r, idle;
    logic [1:0]  t;
    logic [15:0] ms;
    bit keep;

    rstn = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_btn_n", 32'({btn2, btn0}), 32'd3);
    chk("rst_ready", 32'({ready2, ready0}), 32'd3);
    chk("rst_busy",  32'({busy2, busy0}), 32'd0);
    chk("rst_done",  32'({done2, done0}), 32'd0);
    chk("rst_err",   32'({err2, err0}), 32'd0);
    rstn = 1'b1;
    tick_check();

    send(2'b00, 16'd0, 4'd1, 1'b0);
    drain();
    chk("short_done_latency", 32'(done_cyc - acc_cyc), 32'd1201);

    falls = 0; dones = 0;
    send(2'b01, 16'd0, 4'd3, 1'b0);
    drain();
    chk("long_falls", 32'(falls), 32'd3);
    chk("long_dones", 32'(dones), 32'd1);

    send(2'b10, 16'd0, 4'd1, 1'b0);
    send(2'b11, 16'd5, 4'd2, 1'b0);
    drain();

    send(2'b00, 16'd0, 4'd1, 1'b1);
    send(2'b00, 16'd0, 4'd1, 1'b0);
    drain();

    send(2'b01, 16'd0, 4'd1, 1'b0);
    repeat (299) tick_check();
    dones = 0;
    rstn = 1'b0;
    q.delete();
    tick_check();
    tick_check();
    rstn = 1'b1;
    repeat (5) tick_check();
    chk("rst_no_done", 32'(dones), 32'd0);
    send(2'b00, 16'd0, 4'd2, 1'b0);
    drain();

    repeat (12) begin
      r = $urandom_range(0, 9);
      ms = 16'($urandom_range(3, 12));
      t = 2'b10;
      if (r == 6) t = 2'b00;
      if (r == 7) t = 2'b11;
      if (r == 8) ms = 16'd0;
      if (r == 9) ms = 16'($urandom_range(3, 40));
      idle = $urandom_range(0, 4);
      if (idle > 0) begin
        cmd_valid = 1'b0;
        repeat (idle) tick_check();
      end
      keep = ($urandom_range(0, 1) == 1);
      send(t, ms, 4'($urandom_range(0, 3)), keep);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
